// File: rtl/vga_text_ctrl.sv
// VGA 80-column text-mode controller: timing counters, 4-stage text/font fetch pipeline and mono pixel output.
// Optional blinking underline cursor is built when VGA_TEXT_CURSOR_EN is defined.
module vga_text_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_data,
  output logic [6:0]  font_ascii,
  output logic [3:0]  font_row,
  output logic [2:0]  font_col,
  input  logic        font_pixel,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        vga_pix,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  h_cnt_r, v_cnt_r;
  logic [6:0]  col_s;
  logic [4:0]  row_s;
  logic [11:0] addr_s;
  logic        active_s, hs_s, vs_s, first_s, cur_hit_s, frame_wrap_s;
  logic [3:0]  hs_sr_r, vs_sr_r, de_sr_r, first_sr_r;
  logic [2:0]  cur_sr_r;
  logic [3:0]  row_d1_r;
  logic [2:0]  col_d1_r;
  logic        attr_r;

  // Pixel/line counters (stage T0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 10'd0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= 10'd0;
      end else begin
        v_cnt_r <= v_cnt_r + 10'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // T0 decode: visibility, syncs, cell address (row*80 as row*64 + row*16)
  always_comb begin
    col_s        = h_cnt_r[9:3];
    row_s        = v_cnt_r[8:4];
    active_s     = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    hs_s         = ~((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST));
    vs_s         = ~((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST));
    first_s      = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    frame_wrap_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
    addr_s       = {1'b0, row_s, 6'd0} + {3'd0, row_s, 4'd0} + {5'd0, col_s};
  end

`ifdef VGA_TEXT_CURSOR_EN
  logic [4:0] frame_cnt_r;
  logic       blink_r;

  // Blink phase flips once every 32 frames, starting visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 5'd0;
      blink_r     <= 1'b1;
    end else if (frame_wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 5'd1;
      if (frame_cnt_r == 5'd31) begin
        blink_r <= ~blink_r;
      end else begin
        blink_r <= blink_r;
      end
    end else begin
      frame_cnt_r <= frame_cnt_r;
      blink_r     <= blink_r;
    end
  end

  assign cur_hit_s = (col_s == cursor_x) && (row_s == cursor_y) &&
                     (v_cnt_r[3:1] == 3'b111) && blink_r;
`else
  logic cursor_unused_s;
  assign cursor_unused_s = ^{cursor_x, cursor_y, frame_wrap_s};
  assign cur_hit_s       = 1'b0;
`endif

  // T1..T4 pipeline: address, font address, attribute, pixel and aligned sync/enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr_r    <= 4'b1111;
      vs_sr_r    <= 4'b1111;
      de_sr_r    <= 4'b0000;
      first_sr_r <= 4'b0000;
      cur_sr_r   <= 3'b000;
      text_addr  <= 12'd0;
      row_d1_r   <= 4'd0;
      col_d1_r   <= 3'd0;
      font_row   <= 4'd0;
      font_col   <= 3'd0;
      attr_r     <= 1'b0;
      vga_pix    <= 1'b0;
    end else begin
      hs_sr_r    <= {hs_sr_r[2:0], hs_s};
      vs_sr_r    <= {vs_sr_r[2:0], vs_s};
      de_sr_r    <= {de_sr_r[2:0], active_s};
      first_sr_r <= {first_sr_r[2:0], first_s};
      cur_sr_r   <= {cur_sr_r[1:0], cur_hit_s};
      text_addr  <= addr_s;
      row_d1_r   <= v_cnt_r[3:0];
      col_d1_r   <= h_cnt_r[2:0];
      font_row   <= row_d1_r;
      font_col   <= col_d1_r;
      attr_r     <= text_data[7];
      vga_pix    <= (font_pixel ^ attr_r ^ cur_sr_r[2]) & de_sr_r[2];
    end
  end

  assign font_ascii  = text_data[6:0];
  assign vga_hs      = hs_sr_r[3];
  assign vga_vs      = vs_sr_r[3];
  assign vga_de      = de_sr_r[3];
  assign frame_start = first_sr_r[3];

endmodule
